// File: rtl/nfc_arb_pkg.sv
// nfc_arb_pkg: shared widths, FSM encoding and command struct for the NFC command arbiter.
// Contents:
//   OPC_W/LBA_W/LEN_W - command field widths
//   IDLE/ISSUE        - FSM state encoding
//   nfc_cmd_t         - packed {opc, lba, len} command
package nfc_arb_pkg;

    localparam int OPC_W = 16;
    localparam int LBA_W = 48;
    localparam int LEN_W = 24;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    typedef struct packed {
        logic [OPC_W-1:0] opc;
        logic [LBA_W-1:0] lba;
        logic [LEN_W-1:0] len;
    } nfc_cmd_t;

endpackage

// File: rtl/nfc_rr_arbiter.sv
// nfc_rr_arbiter: combinational round-robin grant generator.
// Ports:
//   req      in  REQ_NUM  request vector
//   rr_ptr   in  SRC_W    highest-priority index this cycle
//   en       in  1        grant enable
//   gnt      out REQ_NUM  one-hot grant
//   gnt_idx  out SRC_W    encoded grant index
//   any_gnt  out 1        a grant is being made
module nfc_rr_arbiter #(
    parameter int REQ_NUM = 2,
    parameter int SRC_W   = 3
) (
    input  logic [REQ_NUM-1:0] req,
    input  logic [SRC_W-1:0]   rr_ptr,
    input  logic               en,
    output logic [REQ_NUM-1:0] gnt,
    output logic [SRC_W-1:0]   gnt_idx,
    output logic               any_gnt
);

    logic [REQ_NUM-1:0] masked;
    logic [REQ_NUM-1:0] pick;

    // Requests at or above rr_ptr win first; if none, wrap to the lowest index.
    // The descending scan leaves the lowest set bit of pick as the winner.
    always_comb begin
        masked  = '0;
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        for (int i = 0; i < REQ_NUM; i++)
            masked[i] = req[i] && (i >= int'(rr_ptr));
        pick = (|masked) ? masked : req;
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            if (en && pick[i]) begin
                gnt     = '0;
                gnt[i]  = 1'b1;
                gnt_idx = SRC_W'(i);
                any_gnt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nfc_cmd_arbiter.sv
// nfc_cmd_arbiter: round-robin scheduler sharing one NFC channel command port among requesters.
// Ports:
//   nand_usr_clk/nand_usr_rst      clock, synchronous active-high reset
//   req_valid/req_ready/req_err    per-requester handshake and zero-length reject pulse
//   req_opc/req_lba/req_len        packed per-requester payloads (requester i at slice i)
//   req_fifo_almost_full           channel FIFO backpressure, blocks new grants
//   o_valid/i_ready                channel command handshake
//   o_opc/o_lba/o_len/o_src        issued command and its source index
//   issue_cnt                      total commands issued
//   busy                           FSM is in ISSUE
//   timeout_flag                   sticky watchdog flag (only with NFC_ARB_TIMEOUT_EN)
// Optional macro NFC_ARB_TIMEOUT_EN adds a TIMEOUT_CYC-cycle watchdog on ISSUE.
module nfc_cmd_arbiter
    import nfc_arb_pkg::*;
#(
    parameter int REQ_NUM     = 2,
    parameter int SRC_W       = 3,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                     nand_usr_clk,
    input  logic                     nand_usr_rst,
    input  logic [REQ_NUM-1:0]       req_valid,
    output logic [REQ_NUM-1:0]       req_ready,
    input  logic [REQ_NUM*OPC_W-1:0] req_opc,
    input  logic [REQ_NUM*LBA_W-1:0] req_lba,
    input  logic [REQ_NUM*LEN_W-1:0] req_len,
    output logic [REQ_NUM-1:0]       req_err,
    input  logic                     req_fifo_almost_full,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [OPC_W-1:0]         o_opc,
    output logic [LBA_W-1:0]         o_lba,
    output logic [LEN_W-1:0]         o_len,
    output logic [SRC_W-1:0]         o_src,
    output logic [31:0]              issue_cnt,
    output logic                     busy
`ifdef NFC_ARB_TIMEOUT_EN
    ,
    output logic                     timeout_flag
`endif
);

    logic [0:0]         state_q, state_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    nfc_cmd_t           cmd_q, cmd_d, sel_cmd;
    logic [SRC_W-1:0]   src_q, src_d;
    logic               valid_q, valid_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [REQ_NUM-1:0] err_q, err_d;
    logic [REQ_NUM-1:0] gnt;
    logic [SRC_W-1:0]   gnt_idx;
    logic               any_gnt;

    nfc_rr_arbiter #(.REQ_NUM(REQ_NUM), .SRC_W(SRC_W)) u_rr (
        .req     (req_valid),
        .rr_ptr  (rr_ptr_q),
        .en      (state_q == IDLE && !req_fifo_almost_full),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    // Grant is qualified by req_valid inside the arbiter, so a dropped request is never accepted.
    assign req_ready = gnt;

    always_comb begin
        sel_cmd = '0;
        for (int i = 0; i < REQ_NUM; i++)
            if (gnt[i])
                sel_cmd = '{opc: req_opc[i*OPC_W +: OPC_W],
                            lba: req_lba[i*LBA_W +: LBA_W],
                            len: req_len[i*LEN_W +: LEN_W]};
    end

`ifdef NFC_ARB_TIMEOUT_EN
    logic [31:0] wd_q, wd_d;
    logic        flag_q, flag_d;
    // wd_q holds the number of completed ISSUE cycles; entry from IDLE always sees 0.
    wire         timeout = (state_q == ISSUE) && !i_ready && (wd_q == 32'(TIMEOUT_CYC - 1));
    assign timeout_flag = flag_q;
`else
    wire         timeout = 1'b0;
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYC);
`endif

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cmd_d    = cmd_q;
        src_d    = src_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        err_d    = '0;
        if (state_q == IDLE) begin
            if (any_gnt) begin
                rr_ptr_d = (gnt_idx == SRC_W'(REQ_NUM - 1)) ? '0 : gnt_idx + SRC_W'(1);
                if (sel_cmd.len == '0) begin
                    err_d = gnt;
                end else begin
                    cmd_d   = sel_cmd;
                    src_d   = gnt_idx;
                    valid_d = 1'b1;
                    state_d = ISSUE;
                end
            end
        end else if (i_ready) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + 32'd1;
            state_d = IDLE;
        end else if (timeout) begin
            valid_d = 1'b0;
            err_d   = REQ_NUM'(1) << src_q;
            state_d = IDLE;
        end
    end

    always_ff @(posedge nand_usr_clk) begin
        if (nand_usr_rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cmd_q    <= '0;
            src_q    <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cmd_q    <= cmd_d;
            src_q    <= src_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

`ifdef NFC_ARB_TIMEOUT_EN
    always_comb begin
        wd_d   = (state_q == ISSUE) ? wd_q + 32'd1 : '0;
        flag_d = flag_q || timeout;
    end

    always_ff @(posedge nand_usr_clk) begin
        if (nand_usr_rst) begin
            wd_q   <= '0;
            flag_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            flag_q <= flag_d;
        end
    end
`endif

    assign o_valid   = valid_q;
    assign o_opc     = cmd_q.opc;
    assign o_lba     = cmd_q.lba;
    assign o_len     = cmd_q.len;
    assign o_src     = src_q;
    assign issue_cnt = cnt_q;
    assign req_err   = err_q;
    assign busy      = (state_q != IDLE);

endmodule
